incubator_ctrl_p: RTL and testbench
===================================

// Module: incubator_ctrl_p
// PURPOSE
//  Parametrised incubator temperature controller; next generation of the fixed 8-bit heater/cooler/fan FSM.
//  Adds parametric width and thresholds, minimum dwell time (anti short-cycling), enable, sticky over-temp alarm.
//  Sits between the temperature sensor sample bus and the heater/cooler/fan drivers.
// PARAMETERS
//  TW        8    temperature width, unsigned
//  HEAT_ON   15   IDLE->HEAT when t_q < HEAT_ON
//  HEAT_OFF  30   HEAT->IDLE when t_q > HEAT_OFF
//  COOL_ON   35   IDLE->COOL when t_q > COOL_ON
//  COOL_OFF  25   COOL->IDLE when t_q < COOL_OFF
//  FAN_T2    40   crs=SPD2 threshold (t_q >= FAN_T2)
//  FAN_T3    45   crs=SPD3 threshold (t_q >= FAN_T3)
//  FAN_W     4    crs width
//  SPD1/2/3  4/6/8  fan speed codes
//  MIN_DWELL 4    min cycles in HEAT/COOL before exit; 0 or 1 = no restriction
//  ALARM_HI  100  over-temp level (t_q >= ALARM_HI)
//  ALARM_CNT 3    consecutive over-temp cycles to raise alarm
//  Elaboration check: HEAT_ON < HEAT_OFF < COOL_ON, COOL_OFF < COOL_ON, COOL_ON < FAN_T2 <= FAN_T3.
// PORTS
//  clk     in   1       clock, all logic on rising edge
//  rst     in   1       synchronous reset, active-high
//  en      in   1       1 = regulate; 0 = force IDLE
//  t       in   TW      temperature sample, unsigned
//  heater  out  1       heater drive
//  cooler  out  1       cooler drive
//  crs     out  FAN_W   fan speed code
//  state   out  2       00 IDLE, 01 HEAT, 10 COOL (11 unused)
//  alarm   out  1       sticky over-temp flag
// BEHAVIOUR
//  Reset: state=IDLE, heater=0, cooler=0, crs=0, alarm=0, t_q=0, t_vld=0, dwell=0, ocnt=0.
//  Every edge: t_q<=t, t_vld<=1. FSM holds IDLE while t_vld=0.
//  Latency: t valid before edge n -> t_q at n -> state/heater/cooler/crs at n+1 (2 edges).
//  Outputs registered: HEAT: heater=1 cooler=0 crs=0; IDLE: all 0; COOL: cooler=1, heater=0, crs per rule.
//  crs in COOL: t_q>=FAN_T3 -> SPD3; else t_q>=FAN_T2 -> SPD2; else SPD1; recomputed every cycle.
//  Transitions: IDLE->HEAT (t_q<HEAT_ON), IDLE->COOL (t_q>COOL_ON), HEAT->IDLE, COOL->IDLE. No direct HEAT<->COOL.
//  dwell: cleared on entry to any state, increments per cycle, saturates at MIN_DWELL.
//  Exit from HEAT/COOL only when dwell >= MIN_DWELL-1 (state held >= MIN_DWELL cycles). No dwell on leaving IDLE.
//  Alarm: ocnt counts consecutive cycles with t_q>=ALARM_HI, clears otherwise, saturates at ALARM_CNT.
//  alarm<=1 when ocnt reaches ALARM_CNT; alarm clears only by rst.
//  Priority per cycle: rst > alarm > en=0 > normal FSM.
//  alarm=1: state=COOL, cooler=1, heater=0, crs=SPD3, ignores en and dwell.
//  en=0: next state IDLE regardless of dwell; alarm monitoring continues.
//  en 0->1: normal FSM from IDLE with current t_q, no extra delay.
//  rst mid-HEAT/COOL: all outputs 0 at next edge; alarm cleared.
//  Thresholds are strict compares; t_q==HEAT_ON or t_q==COOL_ON keeps IDLE.
// TESTING
//  rst 1 cyc, en=1, t=80 -> cooler=1, crs=8, state=10 two edges after rst low; heater=0.
//  then t=0 -> COOL held >= 4 cycles total, then IDLE 1 cycle, then HEAT (heater=1).
//  t=20 in HEAT (dwell met) -> stays HEAT; t=31 -> IDLE two edges later; t=15 in IDLE -> stays IDLE.
//  COOL, t=42 -> crs=6; t=36 -> crs=4; t=24 -> IDLE, crs=0.
//  t=100 for 2 cycles then 99 -> no alarm; t=120 for 3 cycles -> alarm=1, crs=8; then en=0, t=20 -> alarm and cooler stay 1 until rst.
//  HEAT with en=0 after 1 cycle -> IDLE next edge (dwell bypassed); rst during COOL -> all outputs 0 next edge.

Source files
------------

// File: rtl/incubator_ctrl_p.sv
// rtl/incubator_ctrl_p.sv - parametrised incubator heater/cooler/fan controller
//
// Purpose:
//   Regulates incubator temperature from a stream of unsigned samples.
//   IDLE/HEAT/COOL FSM with hysteresis thresholds and a minimum dwell time
//   in HEAT/COOL. Fan speed follows temperature while cooling. A sticky
//   over-temperature alarm forces full cooling until reset.
//
// Ports:
//   clk     in   1      clock, rising edge
//   rst     in   1      synchronous reset, active-high
//   en      in   1      1 = regulate, 0 = force IDLE
//   t       in   TW     temperature sample, unsigned
//   heater  out  1      heater drive
//   cooler  out  1      cooler drive
//   crs     out  FAN_W  fan speed code
//   state   out  2      00 IDLE, 01 HEAT, 10 COOL
//   alarm   out  1      sticky over-temperature flag

module incubator_ctrl_p #(
  parameter int unsigned TW        = 8,
  parameter int unsigned HEAT_ON   = 15,
  parameter int unsigned HEAT_OFF  = 30,
  parameter int unsigned COOL_ON   = 35,
  parameter int unsigned COOL_OFF  = 25,
  parameter int unsigned FAN_T2    = 40,
  parameter int unsigned FAN_T3    = 45,
  parameter int unsigned FAN_W     = 4,
  parameter int unsigned SPD1      = 4,
  parameter int unsigned SPD2      = 6,
  parameter int unsigned SPD3      = 8,
  parameter int unsigned MIN_DWELL = 4,
  parameter int unsigned ALARM_HI  = 100,
  parameter int unsigned ALARM_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [TW-1:0]    t,
  output logic             heater,
  output logic             cooler,
  output logic [FAN_W-1:0] crs,
  output logic [1:0]       state,
  output logic             alarm
);

  // Threshold ordering keeps the hysteresis bands sane and HEAT/COOL disjoint.
  if (!((HEAT_ON < HEAT_OFF) && (HEAT_OFF < COOL_ON) && (COOL_OFF < COOL_ON) &&
        (COOL_ON < FAN_T2) && (FAN_T2 <= FAN_T3))) begin : g_bad_thresholds
    $error("incubator_ctrl_p: inconsistent temperature thresholds");
  end

  localparam int unsigned DW = (MIN_DWELL > 1) ? $clog2(MIN_DWELL + 1) : 1;
  localparam int unsigned OW = (ALARM_CNT > 1) ? $clog2(ALARM_CNT + 1) : 1;

  localparam logic [TW-1:0]    HEAT_ON_T  = TW'(HEAT_ON);
  localparam logic [TW-1:0]    HEAT_OFF_T = TW'(HEAT_OFF);
  localparam logic [TW-1:0]    COOL_ON_T  = TW'(COOL_ON);
  localparam logic [TW-1:0]    COOL_OFF_T = TW'(COOL_OFF);
  localparam logic [TW-1:0]    FAN_T2_T   = TW'(FAN_T2);
  localparam logic [TW-1:0]    FAN_T3_T   = TW'(FAN_T3);
  localparam logic [TW-1:0]    ALARM_HI_T = TW'(ALARM_HI);
  localparam logic [FAN_W-1:0] SPD1_C     = FAN_W'(SPD1);
  localparam logic [FAN_W-1:0] SPD2_C     = FAN_W'(SPD2);
  localparam logic [FAN_W-1:0] SPD3_C     = FAN_W'(SPD3);
  localparam logic [DW-1:0]    DWELL_MAX  = DW'(MIN_DWELL);
  // dwell is 0 on the entry cycle, so reaching MIN_DWELL-1 means MIN_DWELL cycles held.
  localparam logic [DW-1:0]    DWELL_EXIT = DW'((MIN_DWELL > 0) ? (MIN_DWELL - 1) : 0);
  localparam logic [OW-1:0]    OCNT_MAX   = OW'(ALARM_CNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAT = 2'b01,
    ST_COOL = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      t_q, t_d;
  logic               t_vld_q, t_vld_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [OW-1:0]      ocnt_q, ocnt_d;
  logic               alarm_q, alarm_d;
  logic               heater_q, heater_d;
  logic               cooler_q, cooler_d;
  logic [FAN_W-1:0]   crs_q, crs_d;
  logic               dwell_ok;

  always_comb begin
    t_d      = t;
    t_vld_d  = 1'b1;
    ocnt_d   = '0;
    alarm_d  = alarm_q;
    state_d  = state_q;
    dwell_d  = '0;
    heater_d = 1'b0;
    cooler_d = 1'b0;
    crs_d    = '0;
    dwell_ok = (MIN_DWELL <= 1) || (dwell_q >= DWELL_EXIT);

    // Consecutive over-temperature counter; any cool sample breaks the run.
    if (t_q >= ALARM_HI_T) begin
      ocnt_d = (ocnt_q >= OCNT_MAX) ? ocnt_q : ocnt_q + 1'b1;
    end
    if (ocnt_d == OCNT_MAX) begin
      alarm_d = 1'b1;
    end

    // Alarm overrides everything else; using alarm_d makes the forced
    // COOL/full fan appear on the same edge the alarm is raised.
    if (alarm_d) begin
      state_d = ST_COOL;
    end else if (!en || !t_vld_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (t_q < HEAT_ON_T) begin
            state_d = ST_HEAT;
          end else if (t_q > COOL_ON_T) begin
            state_d = ST_COOL;
          end
        end
        ST_HEAT: begin
          if ((t_q > HEAT_OFF_T) && dwell_ok) begin
            state_d = ST_IDLE;
          end
        end
        ST_COOL: begin
          if ((t_q < COOL_OFF_T) && dwell_ok) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d == state_q) begin
      dwell_d = (dwell_q >= DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
    end

    heater_d = (state_d == ST_HEAT);
    cooler_d = (state_d == ST_COOL);
    if (alarm_d) begin
      crs_d = SPD3_C;
    end else if (state_d == ST_COOL) begin
      if (t_q >= FAN_T3_T) begin
        crs_d = SPD3_C;
      end else if (t_q >= FAN_T2_T) begin
        crs_d = SPD2_C;
      end else begin
        crs_d = SPD1_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      t_vld_q  <= 1'b0;
      dwell_q  <= '0;
      ocnt_q   <= '0;
      alarm_q  <= 1'b0;
      heater_q <= 1'b0;
      cooler_q <= 1'b0;
      crs_q    <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      t_vld_q  <= t_vld_d;
      dwell_q  <= dwell_d;
      ocnt_q   <= ocnt_d;
      alarm_q  <= alarm_d;
      heater_q <= heater_d;
      cooler_q <= cooler_d;
      crs_q    <= crs_d;
    end
  end

  assign heater = heater_q;
  assign cooler = cooler_q;
  assign crs    = crs_q;
  assign state  = state_q;
  assign alarm  = alarm_q;

endmodule

// File: tb/tb_incubator_ctrl_p.sv
// tb/tb_incubator_ctrl_p.sv - self-checking bench for incubator_ctrl_p
module tb_incubator_ctrl_p;

  localparam int HEAT_ON   = 15;
  localparam int HEAT_OFF  = 30;
  localparam int COOL_ON   = 35;
  localparam int COOL_OFF  = 25;
  localparam int MIN_DWELL = 4;
  localparam int ALARM_HI  = 100;
  localparam int ALARM_CNT = 3;
  localparam int M_IDLE = 0;
  localparam int M_HEAT = 1;
  localparam int M_COOL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] t = 8'd0;
  logic       heater;
  logic       cooler;
  logic [3:0] crs;
  logic [1:0] state;
  logic       alarm;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: mode, how many cycles it has been held, run length of
  // hot samples, and the latched alarm.
  int   m_tq, m_vld, m_mode, m_held, m_run, m_fan;
  bit   m_alarm;
  logic [8:0] exp_vec;

  incubator_ctrl_p dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .t     (t),
    .heater(heater),
    .cooler(cooler),
    .crs   (crs),
    .state (state),
    .alarm (alarm)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [7:0] tv);
    int  nm;
    int  tq_prev;
    bit  ok;
    rst = r;
    en  = e;
    t   = tv;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      m_tq = 0; m_vld = 0; m_mode = M_IDLE; m_held = 1;
      m_run = 0; m_alarm = 0; m_fan = 0;
    end else begin
      tq_prev = m_tq;
      m_run = (tq_prev >= ALARM_HI) ? m_run + 1 : 0;
      if (m_run >= ALARM_CNT) m_alarm = 1'b1;
      ok = (m_held >= MIN_DWELL);
      nm = m_mode;
      if (m_alarm) nm = M_COOL;
      else if (!e || m_vld == 0) nm = M_IDLE;
      else if (m_mode == M_IDLE) begin
        if (tq_prev < HEAT_ON) nm = M_HEAT;
        else if (tq_prev > COOL_ON) nm = M_COOL;
      end else if (m_mode == M_HEAT) begin
        if (tq_prev > HEAT_OFF && ok) nm = M_IDLE;
      end else begin
        if (tq_prev < COOL_OFF && ok) nm = M_IDLE;
      end
      if (m_alarm) m_fan = 8;
      else if (nm == M_COOL) m_fan = (tq_prev >= 45) ? 8 : (tq_prev >= 40) ? 6 : 4;
      else m_fan = 0;
      m_held = (nm == m_mode) ? m_held + 1 : 1;
      m_mode = nm;
      m_tq = int'(tv);
      m_vld = 1;
    end
    exp_vec = {(m_mode == M_HEAT), (m_mode == M_COOL), 4'(m_fan), 2'(m_mode), m_alarm};
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    checks++;
    if ({heater, cooler, crs, state, alarm} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {heater, cooler, crs, state, alarm}, 9'd0);
    end
  endtask

  task automatic test_cool_heat();
    int seq[$] = '{80, 80, 0, 0, 0, 0, 0, 20, 20, 20, 20, 20, 20, 31, 31, 15, 15, 15, 15};
    logic [1:0] st_hist[$];
    step(1'b1, 1'b1, 8'd80);
    foreach (seq[i]) begin
      step(1'b0, 1'b1, 8'(seq[i]));
      st_hist.push_back(state);
      checks++;
      if ({heater, cooler, crs, state, alarm} !== exp_vec) begin
        errors++;
        $display("FAIL cool_heat_model cyc=%0d got=%b exp=%b", cyc, {heater, cooler, crs, state, alarm}, exp_vec);
      end
      if (i == 1) begin
        checks++;
        if ({state, cooler, heater, crs} !== {2'b10, 1'b1, 1'b0, 4'd8}) begin
          errors++;
          $display("FAIL cool_entry got=%b exp=%b", {state, cooler, heater, crs}, {2'b10, 1'b1, 1'b0, 4'd8});
        end
      end
    end
    // COOL must be held 4 cycles (idx 1..4) before one IDLE cycle, then HEAT.
    checks++;
    if ({st_hist[4], st_hist[5], st_hist[6]} !== {2'b10, 2'b00, 2'b01}) begin
      errors++;
      $display("FAIL cool_dwell got=%b exp=%b", {st_hist[4], st_hist[5], st_hist[6]}, {2'b10, 2'b00, 2'b01});
    end
    checks++;
    if ({st_hist[12], st_hist[13], st_hist[14]} !== {2'b01, 2'b01, 2'b00}) begin
      errors++;
      $display("FAIL heat_exit got=%b exp=%b", {st_hist[12], st_hist[13], st_hist[14]}, {2'b01, 2'b01, 2'b00});
    end
    checks++;
    if ({state, heater} !== {2'b00, 1'b0}) begin
      errors++;
      $display("FAIL heat_on_boundary got=%b exp=%b", {state, heater}, 3'b000);
    end
  endtask

  task automatic test_fan_speeds();
    int seq[$] = '{35, 35, 35, 42, 42, 45, 40, 36, 36, 24, 24};
    logic [3:0] crs_hist[$];
    logic [1:0] st_hist[$];
    foreach (seq[i]) begin
      step(1'b0, 1'b1, 8'(seq[i]));
      crs_hist.push_back(crs);
      st_hist.push_back(state);
      checks++;
      if ({heater, cooler, crs, state, alarm} !== exp_vec) begin
        errors++;
        $display("FAIL fan_model cyc=%0d got=%b exp=%b", cyc, {heater, cooler, crs, state, alarm}, exp_vec);
      end
    end
    checks++;
    if (st_hist[2] !== 2'b00) begin
      errors++;
      $display("FAIL cool_on_boundary got=%b exp=00", st_hist[2]);
    end
    checks++;
    if ({crs_hist[4], crs_hist[6], crs_hist[7], crs_hist[8]} !== {4'd6, 4'd8, 4'd6, 4'd4}) begin
      errors++;
      $display("FAIL fan_codes got=%h exp=%h", {crs_hist[4], crs_hist[6], crs_hist[7], crs_hist[8]}, 16'h6864);
    end
    checks++;
    if ({state, cooler, crs} !== 7'd0) begin
      errors++;
      $display("FAIL cool_exit got=%b exp=%b", {state, cooler, crs}, 7'd0);
    end
  endtask

  task automatic test_alarm();
    int seq[$] = '{100, 100, 99, 20, 20, 20, 20, 20, 20, 120, 120, 120, 20};
    step(1'b1, 1'b1, 8'd20);
    foreach (seq[i]) begin
      step(1'b0, 1'b1, 8'(seq[i]));
      checks++;
      if ({heater, cooler, crs, state, alarm} !== exp_vec) begin
        errors++;
        $display("FAIL alarm_model cyc=%0d got=%b exp=%b", cyc, {heater, cooler, crs, state, alarm}, exp_vec);
      end
      if (i == 11) begin
        checks++;
        if (alarm !== 1'b0) begin
          errors++;
          $display("FAIL alarm_early got=%b exp=0", alarm);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'd20);
      checks++;
      if ({alarm, cooler, heater, crs, state} !== {1'b1, 1'b1, 1'b0, 4'd8, 2'b10}) begin
        errors++;
        $display("FAIL alarm_sticky cyc=%0d got=%b exp=%b", cyc, {alarm, cooler, heater, crs, state}, 9'b110100010);
      end
    end
    step(1'b1, 1'b0, 8'd20);
    checks++;
    if ({heater, cooler, crs, state, alarm} !== 9'd0) begin
      errors++;
      $display("FAIL alarm_reset got=%b exp=%b", {heater, cooler, crs, state, alarm}, 9'd0);
    end
  endtask

  task automatic test_enable_bypass();
    step(1'b1, 1'b1, 8'd0);
    step(1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    checks++;
    if ({state, heater} !== {2'b00, 1'b0} || exp_vec !== 9'd0) begin
      errors++;
      $display("FAIL en_bypass got=%b exp=%b", {state, heater}, 3'b000);
    end
    step(1'b0, 1'b1, 8'd0);
    checks++;
    if ({state, heater} !== {2'b01, 1'b1}) begin
      errors++;
      $display("FAIL en_resume got=%b exp=%b", {state, heater}, 3'b011);
    end
  endtask

  task automatic test_reset_mid_cool();
    step(1'b0, 1'b1, 8'd80);
    step(1'b0, 1'b1, 8'd80);
    step(1'b0, 1'b1, 8'd80);
    checks++;
    if ({heater, cooler, crs, state, alarm} !== exp_vec) begin
      errors++;
      $display("FAIL mid_cool_model got=%b exp=%b", {heater, cooler, crs, state, alarm}, exp_vec);
    end
    step(1'b1, 1'b1, 8'd80);
    checks++;
    if ({heater, cooler, crs, state, alarm} !== 9'd0) begin
      errors++;
      $display("FAIL rst_mid_cool got=%b exp=%b", {heater, cooler, crs, state, alarm}, 9'd0);
    end
  endtask

  task automatic test_random();
    logic       r, e;
    logic [7:0] tv;
    step(1'b1, 1'b1, 8'd20);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 19) != 0);
      tv = ($urandom_range(0, 49) == 0) ? 8'($urandom_range(95, 130)) : 8'($urandom_range(0, 60));
      step(r, e, tv);
      checks++;
      if ({heater, cooler, crs, state, alarm} !== exp_vec) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, {heater, cooler, crs, state, alarm}, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cool_heat();
    test_fan_speeds();
    test_alarm();
    test_enable_bypass();
    test_reset_mid_cool();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
